// File: rtl/pe_traffic_gen.sv
`default_nettype none
// ============================================================================
// Module   : pe_traffic_gen
// Purpose  : NoC endpoint traffic generator and sink for the tree NoC.
//            Injects {dest, timestamp} packets into its router port using a
//            run-time selectable destination pattern, a programmable
//            injection gap and a packet limit. Sinks every packet offered by
//            the router and counts received and misrouted packets.
// Ports    : clk, rst              - clock, synchronous active-high reset
//            i_enable              - allow injection of the next packet
//            i_mode                - destination pattern select
//            i_inj_gap             - idle (valid low) cycles between packets
//            o_data/o_data_valid/i_data_ready - TX handshake to router
//            i_data/i_data_valid/o_data_ready - RX handshake from router
//            o_tx_count, o_rx_count, o_misroute_count, o_done_tx - status
//            o_lat_sum, o_lat_max  - latency statistics (optional)
// Options  : define PE_LATENCY_STATS_EN to add the latency statistics ports.
// Revision : 1.0 - initial release
// ============================================================================
module pe_traffic_gen #(
   parameter int Address      = 0,
   parameter int NumPE        = 16,
   parameter int AddressWidth = 4,
   parameter int DataWidth    = 32,
   parameter int PktLimit     = 100
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              i_enable,
   input  logic [2:0]                        i_mode,
   input  logic [15:0]                       i_inj_gap,
   output logic [AddressWidth+DataWidth-1:0] o_data,
   output logic                              o_data_valid,
   input  logic                              i_data_ready,
   input  logic [AddressWidth+DataWidth-1:0] i_data,
   input  logic                              i_data_valid,
   output logic                              o_data_ready,
   output logic [31:0]                       o_tx_count,
   output logic [31:0]                       o_rx_count,
   output logic [15:0]                       o_misroute_count,
   output logic                              o_done_tx
`ifdef PE_LATENCY_STATS_EN
   ,
   output logic [DataWidth+15:0]             o_lat_sum,
   output logic [DataWidth-1:0]              o_lat_max
`endif
);

   localparam int AW = AddressWidth;
   localparam int DW = DataWidth;
   localparam int HALF_AW = AW / 2;

   localparam logic [AW-1:0] ADDR         = AW'(Address);
   localparam logic [AW:0]   NUM_PE       = (AW+1)'(NumPE);
   localparam logic [AW-1:0] DEST_TORNADO = AW'((Address + (NumPE + 1) / 2) % NumPE);
   localparam logic [AW-1:0] DEST_NEIGH   = AW'((Address + 1) % NumPE);
   localparam logic [31:0]   PKT_LIMIT    = 32'(PktLimit);
   // Seed is Address+1 so that PE 0 does not start in the all-zero lock-up state.
   localparam logic [15:0]   LFSR_SEED    = 16'(Address + 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_GAP  = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   state_e               state_q;
   logic [AW+DW-1:0]     data_q;
   logic                 data_valid_q;
   logic                 data_ready_q;
   logic [31:0]          tx_count_q;
   logic [31:0]          rx_count_q;
   logic [15:0]          misroute_count_q;
   logic                 done_q;
   logic [15:0]          gap_cnt_q;
   logic [15:0]          lfsr_q;
   logic [DW-1:0]        ts_q;

   logic [15:0]          lfsr_d;
   logic [AW:0]          rand_ext_d;
   logic [AW-1:0]        rev_d;
   logic [AW-1:0]        rot_d;
   logic [AW-1:0]        trn_d;
   logic [AW-1:0]        dest_d;
   logic [31:0]          tx_count_d;

   // Destination selection for a packet generated on the coming edge.
   always_comb begin
      // Fibonacci LFSR, taps 16,14,13,11.
      lfsr_d     = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      // Low LFSR bits folded once into 0..NumPE-1 (NumPE > 2**(AW-1) makes one fold enough).
      rand_ext_d = {1'b0, lfsr_q[AW-1:0]};
      if (rand_ext_d >= NUM_PE) begin
         rand_ext_d = rand_ext_d - NUM_PE;
      end
      rev_d      = {<<{ADDR}};
      rot_d      = (ADDR >> 1) | (ADDR << (AW - 1));
      trn_d      = (ADDR >> HALF_AW) | (ADDR << (AW - HALF_AW));
      tx_count_d = tx_count_q + 32'd1;
      case (i_mode)
         3'd0:    dest_d = rand_ext_d[AW-1:0];
         3'd1:    dest_d = ~ADDR;
         3'd2:    dest_d = rev_d;
         3'd3:    dest_d = rot_d;
         3'd4:    dest_d = trn_d;
         3'd5:    dest_d = DEST_TORNADO;
         default: dest_d = DEST_NEIGH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q          <= ST_IDLE;
         data_q           <= '0;
         data_valid_q     <= 1'b0;
         data_ready_q     <= 1'b0;
         tx_count_q       <= '0;
         rx_count_q       <= '0;
         misroute_count_q <= '0;
         done_q           <= 1'b0;
         gap_cnt_q        <= '0;
         lfsr_q           <= LFSR_SEED;
         ts_q             <= '0;
      end else begin
         ts_q         <= ts_q + 1'b1;
         data_ready_q <= 1'b1;

         if (i_data_valid) begin
            rx_count_q <= rx_count_q + 32'd1;
            if (i_data[DW +: AW] != ADDR && misroute_count_q != 16'hFFFF) begin
               misroute_count_q <= misroute_count_q + 16'd1;
            end
         end

         case (state_q)
            ST_IDLE: begin
               if (i_enable) begin
                  data_q       <= {dest_d, ts_q};
                  data_valid_q <= 1'b1;
                  lfsr_q       <= lfsr_d;
                  state_q      <= ST_SEND;
               end
            end
            ST_SEND: begin
               if (data_valid_q && i_data_ready) begin
                  tx_count_q <= tx_count_d;
                  if (PKT_LIMIT != 32'd0 && tx_count_d == PKT_LIMIT) begin
                     data_valid_q <= 1'b0;
                     done_q       <= 1'b1;
                     state_q      <= ST_DONE;
                  end else if (i_inj_gap == 16'd0 && i_enable) begin
                     // Back-to-back: next packet replaces the accepted one.
                     data_q       <= {dest_d, ts_q};
                     lfsr_q       <= lfsr_d;
                  end else begin
                     data_valid_q <= 1'b0;
                     gap_cnt_q    <= i_inj_gap;
                     state_q      <= ST_GAP;
                  end
               end
            end
            ST_GAP: begin
               if (gap_cnt_q != 16'd0) begin
                  gap_cnt_q <= gap_cnt_q - 16'd1;
               end
               // Firing at count 1 yields exactly i_inj_gap low cycles; count 0
               // covers a zero gap that was entered only because enable was low.
               if (gap_cnt_q <= 16'd1 && i_enable) begin
                  data_q       <= {dest_d, ts_q};
                  data_valid_q <= 1'b1;
                  lfsr_q       <= lfsr_d;
                  state_q      <= ST_SEND;
               end
            end
            ST_DONE: begin
               done_q <= 1'b1;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_data           = data_q;
   assign o_data_valid     = data_valid_q;
   assign o_data_ready     = data_ready_q;
   assign o_tx_count       = tx_count_q;
   assign o_rx_count       = rx_count_q;
   assign o_misroute_count = misroute_count_q;
   assign o_done_tx        = done_q;

`ifdef PE_LATENCY_STATS_EN
   logic [DW+15:0] lat_sum_q;
   logic [DW-1:0]  lat_max_q;
   logic [DW-1:0]  lat_d;
   logic [DW+16:0] lat_sum_ext_d;

   // Latency in ts ticks, modulo 2**DW so a wrapped timestamp still works.
   always_comb begin
      lat_d         = ts_q - i_data[DW-1:0];
      lat_sum_ext_d = {1'b0, lat_sum_q} + {17'd0, lat_d};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lat_sum_q <= '0;
         lat_max_q <= '0;
      end else if (i_data_valid) begin
         lat_sum_q <= lat_sum_ext_d[DW+16] ? '1 : lat_sum_ext_d[DW+15:0];
         if (lat_d > lat_max_q) begin
            lat_max_q <= lat_d;
         end
      end
   end

   assign o_lat_sum = lat_sum_q;
   assign o_lat_max = lat_max_q;
`else
   // Payload timestamp is only consumed by the latency statistics.
   logic unused_payload;
   assign unused_payload = ^i_data[DW-1:0];
`endif

endmodule
`default_nettype wire

// File: doc/pe_traffic_gen.md
Name: pe_traffic_gen

Overview:
Synthesizable, parametrised NoC endpoint that replaces the behavioural PE model. It injects timestamped packets into its router port using a run-time selectable destination pattern, a programmable injection gap and a packet limit. It also sinks packets from the router and counts received and misrouted packets. One instance sits on each router leaf of the tree NoC.

Parameters:
Address, 0, this PE's own address.
NumPE, 16, number of PEs in the network; must satisfy 2**(AddressWidth-1) < NumPE <= 2**AddressWidth.
AddressWidth, 4, width of the destination field.
DataWidth, 32, width of the payload (timestamp) field.
PktLimit, 100, number of packets to inject before raising done; 0 means unlimited.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
i_enable  in  1  1 = injection allowed
i_mode  in  3  pattern: 0 random, 1 complement, 2 reverse, 3 rotation, 4 transpose, 5 tornado, 6 neighbour, 7 same as neighbour
i_inj_gap  in  16  number of idle cycles (valid low) between packets
o_data  out  AddressWidth+DataWidth  {dest, timestamp}
o_data_valid  out  1  TX valid
i_data_ready  in  1  TX ready from router
i_data  in  AddressWidth+DataWidth  RX packet
i_data_valid  in  1  RX valid
o_data_ready  out  1  RX ready
o_tx_count  out  32  packets accepted by the router
o_rx_count  out  32  packets received
o_misroute_count  out  16  received packets whose dest field != Address
o_done_tx  out  1  PktLimit packets sent

Behaviour:
- Reset (synchronous, active-high): all outputs 0, including o_data_ready. FSM goes to IDLE. Timestamp counter ts = 0. 16-bit LFSR = Address+1 (never zero).
- Leaving reset: o_data_ready = 1 from the first cycle after rst falls, held constant. RX always accepts.
- ts is a free-running DataWidth-bit counter and wraps modulo 2**DataWidth.
- LFSR: x^16+x^14+x^13+x^11+1, Fibonacci form. Advances exactly once per packet generated, never otherwise.
- Destination (d = Address, AW = AddressWidth), evaluated at packet generation using i_mode sampled that cycle:
  - random: r = lfsr[AW-1:0]; if r >= NumPE, subtract NumPE.
  - complement: ~d.
  - reverse: bit j = d[AW-1-j].
  - rotation: bit j = d[(j+1)%AW].
  - transpose: bit j = d[(j+AW/2)%AW].
  - tornado: (d + (NumPE+1)/2) % NumPE.
  - neighbour: (d + 1) % NumPE.
- Packet generation = register o_data <= {dest, ts}, o_data_valid <= 1.
- FSM:
  - IDLE: if i_enable, generate a packet and go to SEND.
  - SEND: on o_data_valid && i_data_ready (transfer), o_tx_count increments.
    - Count reaches PktLimit (PktLimit != 0): o_data_valid <= 0, go to DONE.
    - Else if i_inj_gap == 0 and i_enable: generate the next packet on the same edge and stay in SEND (back-to-back, one packet per cycle at full ready).
    - Else: o_data_valid <= 0, load gap_cnt <= i_inj_gap, go to GAP.
  - GAP: gap_cnt decrements each cycle. When gap_cnt <= 1 and i_enable, generate a packet and go to SEND. With i_inj_gap == 0 and i_enable low, wait here until enable returns. Valid is low for exactly i_inj_gap cycles when enabled.
  - DONE: o_done_tx = 1, sticky until reset. No further injection.
- Handshake rules: o_data is stable while valid is high and ready is low. Valid never drops without a transfer; i_enable low only blocks the next packet. A mode change mid-packet does not alter a pending packet.
- RX: each cycle with i_data_valid = 1, o_rx_count increments. If i_data[DataWidth+:AW] != Address, o_misroute_count also increments (saturates at 0xFFFF).
- Counters: o_tx_count and o_rx_count wrap at 2**32.
- Reset mid-operation: any packet in flight is abandoned (valid low next cycle) and counts are cleared.

Optional Feature:
Macro PE_LATENCY_STATS_EN.
- Defined: adds outputs o_lat_sum (DataWidth+16, saturating) and o_lat_max (DataWidth), both reset to 0. Per received packet, lat = (ts - i_data[DataWidth-1:0]) mod 2**DataWidth. lat is added to o_lat_sum, and o_lat_max is updated if lat is larger. Both update one cycle after the receive.
- Not defined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Address=5, NumPE=16, mode=6, gap=0, PktLimit=4, ready held 1 -> four back-to-back packets, dest=6, timestamps consecutive; o_done_tx=1 after the 4th; o_tx_count=4; valid low thereafter.
- Address=5, mode=1, gap=3, ready stalled low 5 cycles on packet 2 -> o_data held constant during the stall; exactly 3 valid-low cycles between transfers; dest=10.
- Address=3, NumPE=12, AW=4, mode=5 -> dest=9; mode=0 over 200 packets -> every dest < 12; same Address reproduces the identical sequence after reset.
- Inject i_data_valid with dest=5 ×3 and dest=2 ×1 into PE Address=5 -> o_rx_count=4, o_misroute_count=1.
- i_enable dropped while valid high and ready low -> valid stays high until the transfer; no new packet until enable returns; rst pulsed mid-SEND -> valid=0 and all counts 0 the next cycle.
- PE_LATENCY_STATS_EN, ts=100, RX payloads 90 and 70 -> o_lat_sum=40, o_lat_max=30; payload 0xFFFFFFF0 at ts=0x10 -> lat=0x20 (wrap).
